// File: rtl/lcd_pkg.sv
// Shared types, default timing and the LCD power-on init table for the
// 4-bit HD44780 nibble writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    IDLE,
    NIB_HI,
    GAP,
    NIB_LO,
    EXEC_WAIT
  } wr_state_e;

  typedef enum logic [1:0] {
    STB_IDLE,
    STB_SETUP,
    STB_PULSE,
    STB_HOLD
  } stb_state_e;

  localparam int unsigned DEF_T_SETUP      = 2;
  localparam int unsigned DEF_T_PULSE      = 12;
  localparam int unsigned DEF_T_HOLD       = 2;
  localparam int unsigned DEF_T_NIBBLE_GAP = 50;
  localparam int unsigned DEF_T_CMD        = 2000;
  localparam int unsigned DEF_T_CLEAR      = 82000;
  localparam int unsigned DEF_T_INIT_LONG  = 205000;
  localparam int unsigned DEF_T_POWERON    = 750000;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // First INIT_NIBBLES entries go out as a lone low nibble, the rest as bytes.
  localparam int unsigned INIT_NIBBLES = 4;
  localparam logic [2:0]  INIT_LAST    = 3'd7;

  function automatic logic [7:0] init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h03;
      3'd1:    return 8'h03;
      3'd2:    return 8'h03;
      3'd3:    return 8'h02;
      3'd4:    return 8'h28;
      3'd5:    return 8'h06;
      3'd6:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Down-counter reload value; a wait of 0 still takes one cycle.
  function automatic int unsigned ticks(input int unsigned t);
    return (t == 0) ? 0 : t - 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Drives one nibble onto the LCD bus: setup with E low, E pulse, then hold.
// done_o pulses in the last hold cycle.
module lcd_nibble_strobe import lcd_pkg::*; #(
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_PULSE = DEF_T_PULSE,
  parameter int unsigned T_HOLD  = DEF_T_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [3:0] nib_i,
  output logic       done_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [3:0] lcd_d_o
);

  localparam int unsigned CW = $clog2(max2(max2(T_SETUP, T_PULSE), T_HOLD) + 2);
  localparam logic [CW-1:0] LD_SETUP = CW'(ticks(T_SETUP));
  localparam logic [CW-1:0] LD_PULSE = CW'(ticks(T_PULSE));
  localparam logic [CW-1:0] LD_HOLD  = CW'(ticks(T_HOLD));

  stb_state_e    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [3:0]    d_q, d_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= STB_IDLE;
      cnt_q <= '0;
      e_q   <= 1'b0;
      rs_q  <= 1'b0;
      d_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      e_q   <= e_d;
      rs_q  <= rs_d;
      d_q   <= d_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    e_d    = e_q;
    rs_d   = rs_q;
    d_d    = d_q;
    done_o = 1'b0;
    unique case (st_q)
      STB_IDLE: begin
        if (start_i) begin
          st_d  = STB_SETUP;
          cnt_d = LD_SETUP;
          rs_d  = rs_i;
          d_d   = nib_i;
          e_d   = 1'b0;
        end
      end
      STB_SETUP: begin
        if (cnt_q == '0) begin
          st_d  = STB_PULSE;
          cnt_d = LD_PULSE;
          e_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STB_PULSE: begin
        if (cnt_q == '0) begin
          st_d  = STB_HOLD;
          cnt_d = LD_HOLD;
          e_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STB_HOLD: begin
        if (cnt_q == '0) begin
          st_d   = STB_IDLE;
          done_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: st_d = STB_IDLE;
    endcase
  end

  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign lcd_d_o  = d_q;

endmodule

// File: rtl/lcd_nibble_writer.sv
// Handshaked byte writer for a 4-bit HD44780 LCD; runs the power-on init
// sequence itself and then accepts RS+byte requests one at a time.
module lcd_nibble_writer import lcd_pkg::*; #(
  parameter int unsigned T_SETUP      = DEF_T_SETUP,
  parameter int unsigned T_PULSE      = DEF_T_PULSE,
  parameter int unsigned T_HOLD       = DEF_T_HOLD,
  parameter int unsigned T_NIBBLE_GAP = DEF_T_NIBBLE_GAP,
  parameter int unsigned T_CMD        = DEF_T_CMD,
  parameter int unsigned T_CLEAR      = DEF_T_CLEAR,
  parameter int unsigned T_INIT_LONG  = DEF_T_INIT_LONG,
  parameter int unsigned T_POWERON    = DEF_T_POWERON
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       sf_e,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  localparam int unsigned T_MAX = max2(max2(max2(T_CMD, T_CLEAR), max2(T_INIT_LONG, T_POWERON)),
                                       T_NIBBLE_GAP);
  localparam int unsigned TW = $clog2(T_MAX + 2);
  localparam logic [TW-1:0] LD_GAP       = TW'(ticks(T_NIBBLE_GAP));
  localparam logic [TW-1:0] LD_CMD       = TW'(ticks(T_CMD));
  localparam logic [TW-1:0] LD_CLEAR     = TW'(ticks(T_CLEAR));
  localparam logic [TW-1:0] LD_INIT_LONG = TW'(ticks(T_INIT_LONG));
  localparam logic [TW-1:0] LD_POWERON   = TW'(ticks(T_POWERON));

  wr_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    byte_q, byte_d;
  logic          rs_q, rs_d;
  logic          single_q, single_d;
  logic [2:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          ready_q, ready_d;

  logic          launch, launch_rs, launch_single;
  logic [7:0]    launch_byte;
  logic [2:0]    idx_next;
  logic [TW-1:0] exec_ld;
  logic          stb_start, stb_done, stb_rs;
  logic [3:0]    stb_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      timer_q     <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      single_q    <= 1'b0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      single_q    <= single_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
    end
  end

  assign idx_next = idx_q + 3'd1;

  // Lone init nibbles never get the clear/home wait, even the 0x2 one.
  always_comb begin
    if (!init_done_q && idx_q == '0) begin
      exec_ld = LD_INIT_LONG;
    end else if (!single_q && !rs_q && (byte_q == CMD_CLEAR || byte_q == CMD_HOME)) begin
      exec_ld = LD_CLEAR;
    end else begin
      exec_ld = LD_CMD;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    byte_d        = byte_q;
    rs_d          = rs_q;
    single_d      = single_q;
    idx_d         = idx_q;
    init_done_d   = init_done_q;
    launch        = 1'b0;
    launch_byte   = byte_q;
    launch_rs     = rs_q;
    launch_single = 1'b0;
    stb_start     = 1'b0;
    stb_rs        = rs_q;
    stb_nib       = byte_q[3:0];
    unique case (state_q)
      PWR_WAIT: begin
        if (timer_q == LD_POWERON) begin
          timer_d       = '0;
          idx_d         = '0;
          launch        = 1'b1;
          launch_byte   = init_entry(3'd0);
          launch_rs     = 1'b0;
          launch_single = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      IDLE: begin
        if (req_valid && ready_q) begin
          launch      = 1'b1;
          launch_byte = req_data;
          launch_rs   = req_rs;
        end
      end
      NIB_HI: begin
        if (stb_done) begin
          state_d = GAP;
          timer_d = LD_GAP;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          stb_start = 1'b1;
          state_d   = NIB_LO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      NIB_LO: begin
        if (stb_done) begin
          state_d = EXEC_WAIT;
          timer_d = exec_ld;
        end
      end
      EXEC_WAIT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (init_done_q) begin
          state_d = IDLE;
        end else if (idx_q == INIT_LAST) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          idx_d         = idx_next;
          launch        = 1'b1;
          launch_byte   = init_entry(idx_next);
          launch_rs     = 1'b0;
          launch_single = (idx_next < 3'(INIT_NIBBLES));
        end
      end
      default: state_d = PWR_WAIT;
    endcase
    if (launch) begin
      byte_d    = launch_byte;
      rs_d      = launch_rs;
      single_d  = launch_single;
      stb_start = 1'b1;
      stb_rs    = launch_rs;
      stb_nib   = launch_single ? launch_byte[3:0] : launch_byte[7:4];
      state_d   = launch_single ? NIB_LO : NIB_HI;
    end
  end

  assign ready_d = (state_d == IDLE);

  lcd_nibble_strobe #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_HOLD  (T_HOLD)
  ) u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (stb_start),
    .rs_i     (stb_rs),
    .nib_i    (stb_nib),
    .done_o   (stb_done),
    .lcd_e_o  (lcd_e),
    .lcd_rs_o (lcd_rs),
    .lcd_d_o  (lcd_d)
  );

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign sf_e      = 1'b1;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with shortened timing parameters.
module tb_lcd_nibble_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, sf_e, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  int tests = 0;
  int fails = 0;

  logic [4:0] nib_q[$];
  int         wid_q[$];
  int         const_bad = 0;
  int         stable_bad = 0;
  int         width = 0;
  logic       e_prev = 1'b0;
  logic [4:0] prev_rsd = 5'h00;
  logic [3:0] exp_init [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  lcd_nibble_writer #(
    .T_SETUP      (1),
    .T_PULSE      (2),
    .T_HOLD       (1),
    .T_NIBBLE_GAP (3),
    .T_CMD        (5),
    .T_CLEAR      (20),
    .T_INIT_LONG  (8),
    .T_POWERON    (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .init_done (init_done),
    .sf_e      (sf_e),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_d     (lcd_d)
  );

  always #5 clk = ~clk;

  // Bus monitor: logs each E pulse's {rs,d} and width, and flags any change
  // of rs/d across setup->pulse->hold or any toggle of sf_e/lcd_rw.
  initial begin
    forever begin
      @(negedge clk);
      if (sf_e !== 1'b1 || lcd_rw !== 1'b0) const_bad++;
      if (lcd_e === 1'b1) begin
        if ({lcd_rs, lcd_d} !== prev_rsd) stable_bad++;
        if (!e_prev) begin
          nib_q.push_back({lcd_rs, lcd_d});
          width = 1;
        end else begin
          width++;
        end
      end else if (e_prev) begin
        wid_q.push_back(width);
        if (rst_n && {lcd_rs, lcd_d} !== prev_rsd) stable_bad++;
      end
      e_prev   = lcd_e;
      prev_rsd = {lcd_rs, lcd_d};
    end
  end

  task automatic do_byte(input logic rs, input logic [7:0] data, output int lows);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    req_rs = rs; req_data = data; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lows = 0;
    n = 0;
    while (req_ready !== 1'b1 && n < 500) begin
      lows++;
      @(negedge clk);
      n++;
    end
    if (n >= 500) lows = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (lcd_e !== 1'b0) $display("FAIL reset_lcd_e: got %b expected 0", lcd_e);
    if (lcd_e !== 1'b0) fails++;
    tests++; if ({lcd_rs, lcd_d} !== 5'h00) begin fails++; $display("FAIL reset_rs_d: got %h expected 00", {lcd_rs, lcd_d}); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    tests++; if (sf_e !== 1'b1 || lcd_rw !== 1'b0) begin fails++; $display("FAIL reset_sf_rw: got %b%b expected 10", sf_e, lcd_rw); end
  endtask

  task automatic test_init();
    int lows, cyc, fall_cyc, done_cyc, bad_w;
    logic ep;
    nib_q.delete(); wid_q.delete();
    const_bad = 0; stable_bad = 0;
    req_rs = 1'b1; req_data = 8'h55; req_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 2) req_valid = 1'b0;
      if (lcd_e === 1'b1) break;
      lows++;
    end
    tests++; if (lows !== 10) begin fails++; $display("FAIL poweron_e_low: got %0d expected 10", lows); end
    cyc = 0; fall_cyc = -100; done_cyc = -1; ep = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cyc++;
      if (i == 20) req_valid = 1'b1;
      if (i == 22) req_valid = 1'b0;
      if (ep && lcd_e === 1'b0) fall_cyc = cyc;
      ep = lcd_e;
      if (init_done === 1'b1) begin done_cyc = cyc; break; end
    end
    tests++; if (done_cyc < 0) begin fails++; $display("FAIL init_done_timeout: got 0 expected 1"); end
    tests++; if (done_cyc - fall_cyc !== 21) begin fails++; $display("FAIL clear_wait: got %0d expected 21", done_cyc - fall_cyc); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_init: got %b expected 1", req_ready); end
    tests++;
    if (nib_q.size() !== 12) begin
      fails++; $display("FAIL init_nibble_count: got %0d expected 12", nib_q.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        tests++;
        if (nib_q[k] !== {1'b0, exp_init[k]}) begin
          fails++; $display("FAIL init_nibble_%0d: got %h expected %h", k, nib_q[k], {1'b0, exp_init[k]});
        end
      end
    end
    bad_w = 0;
    foreach (wid_q[k]) if (wid_q[k] !== 2) bad_w++;
    tests++; if (bad_w !== 0) begin fails++; $display("FAIL init_e_width: got %0d bad pulses expected 0", bad_w); end
    tests++; if (const_bad !== 0) begin fails++; $display("FAIL sf_e_lcd_rw_const: got %0d bad samples expected 0", const_bad); end
    tests++; if (stable_bad !== 0) begin fails++; $display("FAIL rs_d_stable: got %0d bad samples expected 0", stable_bad); end
  endtask

  task automatic test_char();
    int lows;
    nib_q.delete(); wid_q.delete(); stable_bad = 0;
    req_rs = 1'b1; req_data = 8'h41; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL char_ready_drop: got %b expected 0", req_ready); end
    tests++; if ({lcd_rs, lcd_d} !== 5'h14) begin fails++; $display("FAIL char_upper_first: got %h expected 14", {lcd_rs, lcd_d}); end
    lows = 1;
    for (int i = 0; i < 200 && req_ready !== 1'b1; i++) begin
      if (i == 4) begin req_rs = 1'b0; req_data = 8'h99; req_valid = 1'b1; end
      if (i == 5) req_valid = 1'b0;
      @(negedge clk);
      if (req_ready !== 1'b1) lows++;
    end
    tests++; if (lows !== 16) begin fails++; $display("FAIL char_busy: got %0d expected 16", lows); end
    tests++;
    if (nib_q.size() !== 2 || wid_q.size() !== 2) begin
      fails++; $display("FAIL char_pulse_count: got %0d expected 2", nib_q.size());
    end else begin
      tests++; if (nib_q[0] !== 5'h14) begin fails++; $display("FAIL char_hi: got %h expected 14", nib_q[0]); end
      tests++; if (nib_q[1] !== 5'h11) begin fails++; $display("FAIL char_lo: got %h expected 11", nib_q[1]); end
      tests++; if (wid_q[0] !== 2 || wid_q[1] !== 2) begin fails++; $display("FAIL char_e_width: got %0d/%0d expected 2/2", wid_q[0], wid_q[1]); end
    end
    tests++; if (stable_bad !== 0) begin fails++; $display("FAIL char_rs_d_stable: got %0d expected 0", stable_bad); end
  endtask

  task automatic test_exec_wait();
    logic       v_rs [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] v_dat [4] = '{8'h01, 8'h02, 8'h80, 8'h01};
    int         v_low [4] = '{31, 31, 16, 16};
    int lows;
    for (int k = 0; k < 4; k++) begin
      nib_q.delete(); wid_q.delete();
      do_byte(v_rs[k], v_dat[k], lows);
      tests++;
      if (lows !== v_low[k]) begin
        fails++; $display("FAIL exec_wait_%h_rs%b: got %0d expected %0d", v_dat[k], v_rs[k], lows, v_low[k]);
      end
      tests++;
      if (nib_q.size() !== 2) begin
        fails++; $display("FAIL exec_pulses_%h: got %0d expected 2", v_dat[k], nib_q.size());
      end else if (nib_q[0] !== {v_rs[k], v_dat[k][7:4]} || nib_q[1] !== {v_rs[k], v_dat[k][3:0]}) begin
        fails++; $display("FAIL exec_nibbles_%h: got %h %h expected %h %h", v_dat[k], nib_q[0], nib_q[1],
                          {v_rs[k], v_dat[k][7:4]}, {v_rs[k], v_dat[k][3:0]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int lows;
    logic [4:0] exp_b2b [4] = '{5'h14, 5'h11, 5'h14, 5'h12};
    nib_q.delete(); wid_q.delete();
    req_rs = 1'b1; req_data = 8'h41; req_valid = 1'b1;
    @(negedge clk);
    req_data = 8'h42;
    lows = 1;
    for (int i = 0; i < 200 && req_ready !== 1'b1; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b1) lows++;
    end
    tests++; if (lows !== 16) begin fails++; $display("FAIL b2b_first_busy: got %0d expected 16", lows); end
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_single_ready_cycle: got %b expected 0", req_ready); end
    tests++; if ({lcd_rs, lcd_d} !== 5'h14) begin fails++; $display("FAIL b2b_second_upper: got %h expected 14", {lcd_rs, lcd_d}); end
    lows = 1;
    for (int i = 0; i < 200 && req_ready !== 1'b1; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b1) lows++;
    end
    tests++; if (lows !== 16) begin fails++; $display("FAIL b2b_second_busy: got %0d expected 16", lows); end
    tests++;
    if (nib_q.size() !== 4) begin
      fails++; $display("FAIL b2b_pulse_count: got %0d expected 4", nib_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (nib_q[k] !== exp_b2b[k]) begin
          fails++; $display("FAIL b2b_nibble_%0d: got %h expected %h", k, nib_q[k], exp_b2b[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    req_rs = 1'b1; req_data = 8'h41; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (lcd_e === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL mid_pulse_reached: got 0 expected 1"); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (lcd_e !== 1'b0) begin fails++; $display("FAIL async_reset_lcd_e: got %b expected 0", lcd_e); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL async_reset_ready: got %b expected 0", req_ready); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL async_reset_init_done: got %b expected 0", init_done); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_init();
    test_char();
    test_exec_wait();
    test_back_to_back();
    test_reset_mid();
    test_init();
    test_char();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
